// File: rtl/dffrf_pkg.sv
// Shared widths, sizing helper and the write-priority selector used by the
// dffrf_mrmw register file for both storage update and read bypass.
package dffrf_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned NR_DEF     = 2;
  localparam int unsigned NW_DEF     = 2;

  // Upper bounds of the padded port bundle handed to wsel
  localparam int unsigned MAX_DATA_W = 64;
  localparam int unsigned MAX_ADDR_W = 16;
  localparam int unsigned MAX_NW     = 16;

  typedef struct packed {
    logic                  hit;
    logic [MAX_DATA_W-1:0] data;
  } wsel_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) r++;
    return r;
  endfunction

  // Highest-indexed enabled port whose address matches a wins
  function automatic wsel_t wsel(input logic [MAX_NW-1:0]            we,
                                 input logic [MAX_NW*MAX_ADDR_W-1:0] rw,
                                 input logic [MAX_NW*MAX_DATA_W-1:0] dw,
                                 input logic [MAX_ADDR_W-1:0]        a);
    wsel_t r;
    r = '0;
    for (int unsigned j = 0; j < MAX_NW; j++) begin
      if (we[j] && (rw[j*MAX_ADDR_W +: MAX_ADDR_W] == a)) begin
        r.hit  = 1'b1;
        r.data = dw[j*MAX_DATA_W +: MAX_DATA_W];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dffrf_wr_arb.sv
// Per-entry write arbitration (highest port wins) and same-cycle write
// collision detection for the dffrf_mrmw register file.
module dffrf_wr_arb
  import dffrf_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NW       = NW_DEF,
  parameter int unsigned ZERO_REG = 0,
  localparam int unsigned DEPTH   = 1 << ADDR_W
) (
  input  logic [NW-1:0]        we,
  input  logic [NW*ADDR_W-1:0] rw,
  input  logic [NW*DATA_W-1:0] dw,
  output logic [DEPTH-1:0]     wr_en_c,
  output logic [DATA_W-1:0]    wr_data_c [DEPTH],
  output logic                 coll_nxt_c,
  output logic [ADDR_W-1:0]    coll_addr_nxt_c
);

  logic [MAX_NW-1:0]            we_p;
  logic [MAX_NW*MAX_ADDR_W-1:0] rw_p;
  logic [MAX_NW*MAX_DATA_W-1:0] dw_p;
  logic [DEPTH-1:0]             wsel_pad_unused;

  always_comb begin
    we_p = '0;
    rw_p = '0;
    dw_p = '0;
    for (int unsigned j = 0; j < NW; j++) begin
      we_p[j]                              = we[j];
      rw_p[j*MAX_ADDR_W +: MAX_ADDR_W]     = MAX_ADDR_W'(rw[j*ADDR_W +: ADDR_W]);
      dw_p[j*MAX_DATA_W +: MAX_DATA_W]     = MAX_DATA_W'(dw[j*DATA_W +: DATA_W]);
    end
  end

  // Entry 0 never takes a write when it is the hard-wired zero register
  for (genvar e = 0; e < int'(DEPTH); e++) begin : g_ent
    wsel_t ws;
    assign ws                 = wsel(we_p, rw_p, dw_p, MAX_ADDR_W'(e));
    assign wr_en_c[e]         = ws.hit && !((ZERO_REG != 0) && (e == 0));
    assign wr_data_c[e]       = ws.data[DATA_W-1:0];
    assign wsel_pad_unused[e] = ^ws;
  end

  // Lowest address written by two or more enabled ports
  always_comb begin
    logic [ADDR_W-1:0] a;
    a               = '0;
    coll_nxt_c      = 1'b0;
    coll_addr_nxt_c = '0;
    for (int unsigned j = 0; j < NW; j++) begin
      for (int unsigned k = j + 1; k < NW; k++) begin
        a = rw[j*ADDR_W +: ADDR_W];
        if (we[j] && we[k] && (a == rw[k*ADDR_W +: ADDR_W]) &&
            !((ZERO_REG != 0) && (a == '0))) begin
          if (!coll_nxt_c || (a < coll_addr_nxt_c)) coll_addr_nxt_c = a;
          coll_nxt_c = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dffrf_mrmw.sv
// Multi-read/multi-write flip-flop register file: storage, read muxes with
// optional write bypass, optional registered read stage, collision report.
module dffrf_mrmw
  import dffrf_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NR       = NR_DEF,
  parameter int unsigned NW       = NW_DEF,
  parameter int unsigned READ_LAT = 0,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [NR*ADDR_W-1:0] RA,
  output logic [NR*DATA_W-1:0] DA,
  input  logic [NW-1:0]        WE,
  input  logic [NW*ADDR_W-1:0] RW,
  input  logic [NW*DATA_W-1:0] DW,
  output logic                 COLL,
  output logic [ADDR_W-1:0]    COLL_ADDR
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  wr_en;
  logic [DATA_W-1:0] wr_data [DEPTH];
  logic              coll_nxt;
  logic [ADDR_W-1:0] coll_addr_nxt;

  dffrf_wr_arb #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NW       (NW),
    .ZERO_REG (ZERO_REG)
  ) u_arb (
    .we              (WE),
    .rw              (RW),
    .dw              (DW),
    .wr_en_c         (wr_en),
    .wr_data_c       (wr_data),
    .coll_nxt_c      (coll_nxt),
    .coll_addr_nxt_c (coll_addr_nxt)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned e = 0; e < DEPTH; e++) mem[e] <= '0;
    end else begin
      for (int unsigned e = 0; e < DEPTH; e++) begin
        if (wr_en[e]) mem[e] <= wr_data[e];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      COLL      <= 1'b0;
      COLL_ADDR <= '0;
    end else begin
      COLL      <= coll_nxt;
      COLL_ADDR <= coll_addr_nxt;
    end
  end

  logic [MAX_NW-1:0]            we_p;
  logic [MAX_NW*MAX_ADDR_W-1:0] rw_p;
  logic [MAX_NW*MAX_DATA_W-1:0] dw_p;
  logic [NR-1:0]                bypass_pad_unused;

  always_comb begin
    we_p = '0;
    rw_p = '0;
    dw_p = '0;
    for (int unsigned j = 0; j < NW; j++) begin
      we_p[j]                          = WE[j];
      rw_p[j*MAX_ADDR_W +: MAX_ADDR_W] = MAX_ADDR_W'(RW[j*ADDR_W +: ADDR_W]);
      dw_p[j*MAX_DATA_W +: MAX_DATA_W] = MAX_DATA_W'(DW[j*DATA_W +: DATA_W]);
    end
  end

  // With BYPASS the write inputs reach DA combinationally (or the DA flops)
  for (genvar i = 0; i < int'(NR); i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              zero;
    wsel_t             ws;
    logic [DATA_W-1:0] rd_c;

    assign ra   = RA[i*ADDR_W +: ADDR_W];
    assign zero = (ZERO_REG != 0) && (ra == '0);
    assign ws   = wsel(we_p, rw_p, dw_p, MAX_ADDR_W'(ra));
    assign rd_c = zero                      ? '0                   :
                  ((BYPASS != 0) && ws.hit) ? ws.data[DATA_W-1:0]  :
                                              mem[ra];
    assign bypass_pad_unused[i] = ^ws;

    if (READ_LAT != 0) begin : g_reg
      logic [DATA_W-1:0] rd_q;
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) rd_q <= '0;
        else        rd_q <= rd_c;
      end
      assign DA[i*DATA_W +: DATA_W] = rd_q;
    end else begin : g_comb
      assign DA[i*DATA_W +: DATA_W] = rd_c;
    end
  end

endmodule
